ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader_if.sv | 25 ++
 rtl/ccff_chain_loader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake plus serial ccff chain signals for ccff_chain_loader.
interface ccff_chain_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              tail_parity;

    modport slave (
        input  start, cfg_data, cfg_valid, ccff_tail,
        output cfg_ready, ccff_head, ccff_clk_en, busy, done, tail_parity
    );

    modport master (
        output start, cfg_data, cfg_valid, ccff_tail,
        input  cfg_ready, ccff_head, ccff_clk_en, busy, done, tail_parity
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first into a ccff configuration chain of CHAIN_LEN flops.
// Optional tail parity accumulation is enabled by defining CCFF_TAIL_PARITY_EN.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 17,
    parameter int unsigned WORD_W    = 8
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    ccff_chain_loader_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic              done_q, done_d;

    logic last_bit;
    logic more_after;
    logic ready;
    logic accept;
    logic load_end;

    // cnt_q counts bits moved from the buffer into the head register, so it
    // reaches CHAIN_LEN one cycle before the final shift is visible on the chain.
    always_comb begin
        last_bit   = (idx_q == IDX_W'(WORD_W - 1)) || (cnt_q == CNT_W'(CHAIN_LEN - 1));
        more_after = cnt_q < CNT_W'(CHAIN_LEN - 1);
        load_end   = (state_q == LOAD) && (cnt_q == CNT_W'(CHAIN_LEN));
        ready      = 1'b0;
        if (state_q == LOAD) begin
            if (!buf_vld_q) begin
                ready = cnt_q < CNT_W'(CHAIN_LEN);
            end else begin
                ready = last_bit && more_after;
            end
        end
        accept = ready && bus.cfg_valid;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        idx_d     = idx_q;
        head_d    = head_q;
        en_d      = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = LOAD;
                    cnt_d     = '0;
                    buf_vld_d = 1'b0;
                    idx_d     = '0;
                end
            end
            LOAD: begin
                if (buf_vld_q) begin
                    head_d = buf_q[idx_q];
                    en_d   = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        buf_vld_d = 1'b0;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                // A word may land in the same cycle the previous word's last bit leaves.
                if (accept) begin
                    buf_d     = bus.cfg_data;
                    buf_vld_d = 1'b1;
                    idx_d     = '0;
                end
                if (load_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            idx_q     <= '0;
            head_q    <= 1'b0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            idx_q     <= idx_d;
            head_q    <= head_d;
            en_q      <= en_d;
            done_q    <= done_d;
        end
    end

    assign bus.cfg_ready   = ready;
    assign bus.ccff_head   = head_q;
    assign bus.ccff_clk_en = en_q;
    assign bus.busy        = (state_q == LOAD);
    assign bus.done        = done_q;

`ifdef CCFF_TAIL_PARITY_EN
    logic par_acc_q, par_acc_d;
    logic tail_par_q, tail_par_d;

    // The last shift cycle's tail bit is folded in on the same edge it is published.
    always_comb begin
        par_acc_d  = par_acc_q;
        tail_par_d = tail_par_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                par_acc_d = 1'b0;
            end
        end else if (en_q) begin
            par_acc_d = par_acc_q ^ bus.ccff_tail;
        end
        if (load_end) begin
            tail_par_d = par_acc_d;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            par_acc_q  <= 1'b0;
            tail_par_q <= 1'b0;
        end else begin
            par_acc_q  <= par_acc_d;
            tail_par_q <= tail_par_d;
        end
    end

    assign bus.tail_parity = tail_par_q;
`else
    logic unused_tail;
    assign unused_tail     = bus.ccff_tail;
    assign bus.tail_parity = 1'b0;
`endif

endmodule
